// File: rtl/mode2_sub_ctrl_pkg.sv
// rtl/mode2_sub_ctrl_pkg.sv - shared widths, state encoding and latency default for the mode-2 subtract controller
package mode2_sub_ctrl_pkg;

  // Half-precision operand layout shared with the softmax datapath.
  localparam int MANTISSA  = 10;
  localparam int EXPONENT  = 5;
  localparam int DATAWIDTH = 1 + EXPONENT + MANTISSA;

  // Controller state encoding.
  localparam logic [1:0] M2S_IDLE  = 2'd0;
  localparam logic [1:0] M2S_RUN   = 2'd1;
  localparam logic [1:0] M2S_DRAIN = 2'd2;
  localparam logic [1:0] M2S_DONE  = 2'd3;

  // Default register depth of the subtract datapath (0 = combinational).
  localparam int M2S_SUB_LATENCY = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = M2S_IDLE,
    ST_RUN   = M2S_RUN,
    ST_DRAIN = M2S_DRAIN,
    ST_DONE  = M2S_DONE
  } m2s_state_t;

endpackage

// File: rtl/mode2_sub_valid_pipe.sv
// rtl/mode2_sub_valid_pipe.sv - {valid, offset} delay line tracking words through the read and subtract stages
module mode2_sub_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int OW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [OW-1:0] in_offset,
  output logic          out_valid,
  output logic [OW-1:0] out_offset,
  output logic          any_valid,
  output logic          upstream_valid
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OW-1:0]    offset_q [DEPTH];
  logic [OW-1:0]    offset_d [DEPTH];

  // Shift one stage per enabled cycle; hold everything otherwise.
  always_comb begin
    valid_d  = valid_q;
    offset_d = offset_q;
    if (en) begin
      valid_d[0]  = in_valid;
      offset_d[0] = in_offset;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i]  = valid_q[i-1];
        offset_d[i] = offset_q[i-1];
      end
    end
  end

  // Stage registers, cleared asynchronously so a reset abandons in-flight words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) offset_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      offset_q <= offset_d;
    end
  end

  // Any valid entry short of the output stage means the pass is not yet drained.
  always_comb begin
    upstream_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) upstream_valid = upstream_valid | valid_q[i];
  end

  assign any_valid  = |valid_q;
  assign out_valid  = valid_q[DEPTH-1];
  assign out_offset = offset_q[DEPTH-1];

endmodule

// File: rtl/mode2_sub_ctrl.sv
// rtl/mode2_sub_ctrl.sv - mode-2 subtract pass sequencer; optional stall counter under MODE2_SUB_CTRL_PERF_EN
module mode2_sub_ctrl
  import mode2_sub_ctrl_pkg::*;
#(
  parameter int ADDRWIDTH   = 8,
  parameter int SUB_LATENCY = M2S_SUB_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDRWIDTH:0]   vec_len,
  input  logic [ADDRWIDTH-1:0] rd_base,
  input  logic [ADDRWIDTH-1:0] wr_base,
  input  logic [DATAWIDTH-1:0] max_in,
  input  logic                 out_ready,
  output logic                 rd_en,
  output logic [ADDRWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0] sub_b,
  output logic                 sub_en,
  output logic                 wr_en,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic                 busy,
`ifdef MODE2_SUB_CTRL_PERF_EN
  output logic [15:0]          stall_cycles,
`endif
  output logic                 done
);

  localparam int DEPTH = 1 + SUB_LATENCY;

  m2s_state_t           state_q, state_d;
  logic [ADDRWIDTH-1:0] rd_base_q, rd_base_d;
  logic [ADDRWIDTH-1:0] wr_base_q, wr_base_d;
  logic [DATAWIDTH-1:0] max_q, max_d;
  logic [ADDRWIDTH:0]   len_q, len_d;
  logic [ADDRWIDTH:0]   issued_q, issued_d;
  logic                 issue;
  logic                 pipe_out_valid;
  logic [ADDRWIDTH-1:0] pipe_out_offset;
  logic                 pipe_any_valid;
  logic                 pipe_upstream_valid;

  // Next-state, operand latching and read issue.
  always_comb begin
    state_d   = state_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    max_d     = max_q;
    len_d     = len_q;
    issued_d  = issued_q;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            rd_base_d = rd_base;
            wr_base_d = wr_base;
            max_d     = max_in;
            len_d     = vec_len;
            issued_d  = '0;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (out_ready) begin
          issue    = 1'b1;
          issued_d = issued_q + 1'b1;
          if (issued_q == len_q - 1'b1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once the last word is either gone or being written this cycle.
        if (!pipe_any_valid || (out_ready && !pipe_upstream_valid)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched pass parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rd_base_q <= '0;
      wr_base_q <= '0;
      max_q     <= '0;
      len_q     <= '0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      max_q     <= max_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
    end
  end

  mode2_sub_valid_pipe #(
    .DEPTH(DEPTH),
    .OW   (ADDRWIDTH)
  ) u_valid_pipe (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (out_ready),
    .in_valid      (issue),
    .in_offset     (issued_q[ADDRWIDTH-1:0]),
    .out_valid     (pipe_out_valid),
    .out_offset    (pipe_out_offset),
    .any_valid     (pipe_any_valid),
    .upstream_valid(pipe_upstream_valid)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign rd_en   = issue;
  assign rd_addr = rd_base_q + issued_q[ADDRWIDTH-1:0];
  assign sub_b   = max_q;
  assign sub_en  = busy & out_ready;
  assign wr_en   = pipe_out_valid & out_ready;
  assign wr_addr = wr_base_q + pipe_out_offset;

`ifdef MODE2_SUB_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of busy cycles lost to backpressure.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) stall_d = '0;
    else if (busy && !out_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mode2_sub_ctrl.sv
// tb/tb_mode2_sub_ctrl.sv - scoreboard bench for mode2_sub_ctrl
module tb_mode2_sub_ctrl;
  import mode2_sub_ctrl_pkg::*;

  localparam int L = 2;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    int         stalls;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [8:0]           vec_len = '0;
  logic [7:0]           rd_base = '0;
  logic [7:0]           wr_base = '0;
  logic [DATAWIDTH-1:0] max_in = '0;
  logic                 out_ready = 1'b0;
  logic                 rd_en, sub_en, wr_en, busy, done;
  logic [7:0]           rd_addr, wr_addr;
  logic [DATAWIDTH-1:0] sub_b;
`ifdef MODE2_SUB_CTRL_PERF_EN
  logic [15:0]          stall_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit exp_busy = 1'b0;
  logic [DATAWIDTH-1:0] exp_max = '0;
  exp_t rd_q[$];
  exp_t wr_q[$];
  exp_t done_q[$];

  mode2_sub_ctrl #(
    .ADDRWIDTH  (8),
    .SUB_LATENCY(L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .vec_len     (vec_len),
    .rd_base     (rd_base),
    .wr_base     (wr_base),
    .max_in      (max_in),
    .out_ready   (out_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .sub_b       (sub_b),
    .sub_en      (sub_en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
`ifdef MODE2_SUB_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic report(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    report({tag, "_rd_en"}, rd_en, 0);
    report({tag, "_wr_en"}, wr_en, 0);
    report({tag, "_busy"}, busy, 0);
    report({tag, "_done"}, done, 0);
    report({tag, "_sub_en"}, sub_en, 0);
    report({tag, "_rd_addr"}, rd_addr, 0);
    report({tag, "_wr_addr"}, wr_addr, 0);
    report({tag, "_sub_b"}, sub_b, 0);
`ifdef MODE2_SUB_CTRL_PERF_EN
    report({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
  endtask

  // Monitor: compare DUT strobes against queued expectations away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && mon_en) begin
      report("busy", busy, exp_busy);
      report("sub_en", sub_en, exp_busy & out_ready);
      if (!out_ready) report("strobe_in_stall", rd_en | wr_en, 0);
      if (rd_en) begin
        if (rd_q.size() == 0) report("rd_unexpected", rd_en, 0);
        else begin
          e = rd_q.pop_front();
          report("rd_cycle", cyc, e.cyc);
          report("rd_addr", rd_addr, e.addr);
          report("sub_b", sub_b, exp_max);
        end
      end
      while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        report("rd_missing", rd_en, 1);
      end
      if (wr_en) begin
        if (wr_q.size() == 0) report("wr_unexpected", wr_en, 0);
        else begin
          e = wr_q.pop_front();
          report("wr_cycle", cyc, e.cyc);
          report("wr_addr", wr_addr, e.addr);
        end
      end
      while (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        e = wr_q.pop_front();
        report("wr_missing", wr_en, 1);
      end
      if (done) begin
        if (done_q.size() == 0) report("done_unexpected", done, 0);
        else begin
          e = done_q.pop_front();
          report("done_cycle", cyc, e.cyc);
`ifdef MODE2_SUB_CTRL_PERF_EN
          report("stall_cycles", stall_cycles, e.stalls);
`endif
        end
      end
      while (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
        e = done_q.pop_front();
        report("done_missing", done, 1);
      end
    end
  end

  // One pass: mode 0 = always ready, 1 = random stalls, 2 = stalls in cycles 2 and 3.
  task automatic run_pass(input int n, input logic [7:0] rb, input logic [7:0] wb,
                          input logic [DATAWIDTH-1:0] mx, input int mode);
    int   r = 0;
    int   c = 0;
    int   stalls = 0;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; vec_len = 9'(n); rd_base = rb; wr_base = wb; max_in = mx;
    out_ready = 1'b1; exp_busy = 1'b0;
    if (n != 0) exp_max = mx;
    if (n == 0) begin
      e = '{cyc: cyc + 1, addr: 8'h00, stalls: 0};
      done_q.push_back(e);
    end else begin
      forever begin
        @(posedge clk); #1;
        c++;
        start = ($urandom_range(0, 3) == 0);
        vec_len = 9'($urandom); rd_base = 8'($urandom); wr_base = 8'($urandom);
        max_in = DATAWIDTH'($urandom);
        exp_busy = 1'b1;
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = !(c == 2 || c == 3);
        endcase
        if (out_ready) begin
          r++;
          if (r <= n) begin
            e = '{cyc: cyc, addr: rb + 8'(r - 1), stalls: 0};
            rd_q.push_back(e);
          end
          if (r >= 2 + L && r <= n + 1 + L) begin
            e = '{cyc: cyc, addr: wb + 8'(r - 2 - L), stalls: 0};
            wr_q.push_back(e);
          end
          if (r == n + 1 + L) begin
            e = '{cyc: cyc + 1, addr: 8'h00, stalls: stalls};
            done_q.push_back(e);
            break;
          end
        end else begin
          stalls++;
        end
        if (c > 4000) begin
          report("pass_timeout", c, 0);
          break;
        end
      end
    end
    // Done cycle: a start here must be ignored.
    @(posedge clk); #1;
    start = 1'b1; vec_len = 9'd5; out_ready = ($urandom_range(0, 1) != 0);
    exp_busy = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0; exp_busy = 1'b0; out_ready = ($urandom_range(0, 1) != 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1; mon_en = 1'b1;
    idle_cycle();

    run_pass(4, 8'h10, 8'h40, 16'h3C00, 0);
    run_pass(3, 8'h20, 8'h50, 16'h4100, 0);
    run_pass(4, 8'h00, 8'h80, 16'h1234, 2);
    run_pass(0, 8'h33, 8'h44, 16'hBEEF, 0);
    idle_cycle();
    run_pass(3, 8'hFE, 8'hFF, 16'h5555, 0);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of a pass.
    @(posedge clk); #1;
    mon_en = 1'b0; start = 1'b1; vec_len = 9'd10; rd_base = 8'h70; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    report("pre_reset_busy", busy, 1);
    #2; reset_n = 1'b0; #1;
    check_all_zero("midreset");
    rd_q.delete(); wr_q.delete(); done_q.delete();
    exp_busy = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0; mon_en = 1'b1;
    run_pass(5, 8'h70, 8'h90, 16'h0F0F, 0);

    for (int i = 0; i < 40; i++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 8);
      run_pass(n, 8'($urandom), 8'($urandom), DATAWIDTH'($urandom), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    report("queues_drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
